// File: rtl/cmm_run_sequencer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cmm_pkg : shared widths, FSM state and row-FIFO entry for cmm_run_sequencer
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
package cmm_pkg;

  localparam int ELEM_W    = 32;
  localparam int ELEMS     = 8;
  localparam int ROW_W     = ELEM_W * ELEMS;
  localparam int ROW_IDX_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_KICK  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FIN   = 3'd4
  } seq_state_t;

  typedef struct packed {
    logic [ROW_IDX_W-1:0] row;
    logic [ROW_W-1:0]     data;
  } row_entry_t;

endpackage
`default_nettype wire

// File: rtl/cmm_run_sequencer_row_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cmm_row_fifo : synchronous row FIFO, push allowed when full if popping
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module cmm_row_fifo #(
  parameter int WIDTH = 261,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr] <= push_data;
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign pop_data = r_mem[r_rd_ptr];
  assign count    = r_count;
  assign full     = (r_count == CNT_W'(DEPTH));
  assign empty    = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/cmm_run_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cmm_run_sequencer : kicks N multiplier runs, buffers result rows and
//                     streams them out as 32-bit elements over valid/ready
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module cmm_run_sequencer
  import cmm_pkg::*;
#(
  parameter int ROWS       = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 job_start,
  input  logic [7:0]           job_count,
  output logic                 busy,
  output logic                 job_done,
  output logic                 cmm_start,
  input  logic                 cmm_done_row,
  input  logic [ROW_IDX_W-1:0] cmm_row_num,
  input  logic [ROW_W-1:0]     cmm_out,
  input  logic                 cmm_done,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [ELEM_W-1:0]    m_data,
  output logic [ROW_IDX_W-1:0] m_row,
  output logic                 m_last,
  output logic                 overflow,
  output logic                 seq_err
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int IDX_W = $clog2(ELEMS);
  localparam logic [ROW_IDX_W-1:0] LAST_ROW = ROW_IDX_W'(ROWS - 1);
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(ELEMS - 1);

  seq_state_t           r_state;
  logic                 r_row_prev;
  logic                 r_done_prev;
  logic [7:0]           r_runs_left;
  logic [ROW_IDX_W-1:0] r_exp_row;
  logic [ROW_W-1:0]     r_ser_data;
  logic [IDX_W-1:0]     r_idx;

  row_entry_t           w_push_entry;
  row_entry_t           w_head;
  logic                 w_row_ev;
  logic                 w_done_ev;
  logic                 w_row_in_run;
  logic                 w_ser_free;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_full;
  logic                 w_empty;
  logic [CNT_W-1:0]     w_count;
  logic [IDX_W-1:0]     w_next_idx;

  assign w_row_ev     = cmm_done_row & ~r_row_prev;
  assign w_done_ev    = cmm_done & ~r_done_prev;
  assign w_row_in_run = w_row_ev && (r_state == ST_RUN);
  // Serializer can take a new row while its final element is being accepted.
  assign w_ser_free   = !m_valid || (m_ready && (r_idx == LAST_IDX));
  assign w_pop        = w_ser_free && !w_empty;
  assign w_push       = w_row_in_run && (!w_full || w_pop);
  assign w_push_entry = '{row: cmm_row_num, data: cmm_out};
  assign w_next_idx   = r_idx + 1'b1;

  cmm_row_fifo #(
    .WIDTH ($bits(row_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_row_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (w_push_entry),
    .pop       (w_pop),
    .pop_data  (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_row_prev  <= 1'b0;
      r_done_prev <= 1'b0;
    end else begin
      r_row_prev  <= cmm_done_row;
      r_done_prev <= cmm_done;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_runs_left <= '0;
      r_exp_row   <= '0;
      busy        <= 1'b0;
      job_done    <= 1'b0;
      cmm_start   <= 1'b0;
      overflow    <= 1'b0;
      seq_err     <= 1'b0;
    end else begin
      cmm_start <= 1'b0;
      job_done  <= 1'b0;
      if (w_row_in_run) begin
        r_exp_row <= r_exp_row + 1'b1;
        if (!w_push) overflow <= 1'b1;
        if (cmm_row_num != r_exp_row) seq_err <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (job_start) begin
            r_runs_left <= (job_count == 8'd0) ? 8'd1 : job_count;
            overflow    <= 1'b0;
            seq_err     <= 1'b0;
            busy        <= 1'b1;
            cmm_start   <= 1'b1;
            r_state     <= ST_KICK;
          end
        end
        ST_KICK: begin
          r_exp_row <= '0;
          r_state   <= ST_RUN;
        end
        ST_RUN: begin
          // A row arriving with DONE is already pushed above.
          if (w_done_ev) begin
            r_runs_left <= r_runs_left - 1'b1;
            r_state     <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if ((w_count == '0) && !m_valid) begin
            if (r_runs_left != 8'd0) begin
              cmm_start <= 1'b1;
              r_state   <= ST_KICK;
            end else begin
              job_done <= 1'b1;
              r_state  <= ST_FIN;
            end
          end
        end
        ST_FIN: begin
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_row      <= '0;
      m_last     <= 1'b0;
      r_idx      <= '0;
      r_ser_data <= '0;
    end else if (w_pop) begin
      m_valid    <= 1'b1;
      r_ser_data <= w_head.data;
      r_idx      <= '0;
      m_data     <= w_head.data[ELEM_W-1:0];
      m_row      <= w_head.row;
      m_last     <= (w_head.row == LAST_ROW) && (LAST_IDX == '0);
    end else if (m_valid && m_ready) begin
      if (r_idx == LAST_IDX) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end else begin
        r_idx  <= w_next_idx;
        m_data <= r_ser_data[ELEM_W*w_next_idx +: ELEM_W];
        m_last <= (m_row == LAST_ROW) && (w_next_idx == LAST_IDX);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cmm_run_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cmm_run_sequencer : directed + randomized bench with a queue-based model
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module tb_cmm_run_sequencer;
  import cmm_pkg::*;

  localparam int ROWS  = 4;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         job_start = 1'b0;
  logic [7:0]   job_count = 8'd0;
  logic         busy, job_done, cmm_start;
  logic         cmm_done_row = 1'b0;
  logic [4:0]   cmm_row_num = 5'd0;
  logic [255:0] cmm_out = '0;
  logic         cmm_done = 1'b0;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [31:0]  m_data;
  logic [4:0]   m_row;
  logic         m_last, overflow, seq_err;

  cmm_run_sequencer #(.ROWS(ROWS), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .job_start(job_start), .job_count(job_count),
    .busy(busy), .job_done(job_done), .cmm_start(cmm_start),
    .cmm_done_row(cmm_done_row), .cmm_row_num(cmm_row_num), .cmm_out(cmm_out),
    .cmm_done(cmm_done), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_row(m_row), .m_last(m_last), .overflow(overflow), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  row;
    logic        last;
  } elem_t;

  elem_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0;
  int last_acc_edge = -100;
  int n_start = 0, n_jd = 0, n_last = 0;
  int rdy_mode = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Downstream ready pattern generator.
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ~m_ready;
      2:       m_ready = ($urandom_range(0, 3) != 0);
      default: m_ready = 1'b0;
    endcase
  end

  // Output monitor: every accepted element is checked against the model queue.
  initial begin : mon
    elem_t       e;
    logic        prev_stall;
    logic        prev_busy;
    logic [37:0] hold;
    prev_stall = 1'b0;
    prev_busy  = 1'b0;
    hold       = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
        prev_busy  = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_valid", m_valid, 1);
          chk("stall_hold", {m_last, m_row, m_data}, hold);
        end
        if (cmm_start) begin
          n_start++;
          chk("kick_drained", exp_q.size(), 0);
          if (prev_busy) chk("kick_latency", cyc, last_acc_edge + 1);
        end
        if (job_done) begin
          n_jd++;
          chk("jobdone_latency", cyc, last_acc_edge + 1);
        end
        if (m_valid && m_ready) begin
          chk("elem_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("m_data", m_data, e.data);
            chk("m_row", m_row, e.row);
            chk("m_last", m_last, e.last);
          end
          if (m_last) n_last++;
          last_acc_edge = cyc + 1;
        end
        prev_stall = m_valid && !m_ready;
        hold       = {m_last, m_row, m_data};
        prev_busy  = busy;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({"zero_ctl_", tag}, {busy, job_done, cmm_start, m_valid, m_last, overflow, seq_err, m_row}, 0);
    chk({"zero_data_", tag}, m_data, 0);
  endtask

  task automatic start_job(input logic [7:0] cnt);
    job_count = cnt;
    job_start = 1'b1;
    tick(1);
    job_start = 1'b0;
    chk("busy_on_start", busy, 1);
    chk("kick_on_start", cmm_start, 1);
    chk("flags_cleared", {overflow, seq_err}, 0);
  endtask

  task automatic wait_start(input int target);
    int t = 0;
    while (n_start < target && t < 2000) begin
      tick(1);
      t++;
    end
    chk("start_seen", n_start >= target, 1);
  endtask

  task automatic wait_jd(input int target);
    int t = 0;
    while (n_jd < target && t < 3000) begin
      tick(1);
      t++;
    end
    chk("jobdone_seen", n_jd >= target, 1);
  endtask

  // Keeps rows in flight below FIFO capacity so random runs never overflow.
  task automatic wait_room();
    int t = 0;
    while ((exp_q.size() + ELEMS - 1) / ELEMS >= DEPTH && t < 2000) begin
      tick(1);
      t++;
    end
    chk("room_seen", (exp_q.size() + ELEMS - 1) / ELEMS < DEPTH, 1);
  endtask

  task automatic expect_row(input logic [4:0] num, input logic [255:0] data);
    for (int i = 0; i < ELEMS; i++) begin
      elem_t e;
      e.data = data[32*i +: 32];
      e.row  = num;
      e.last = (num == 5'(ROWS - 1)) && (i == ELEMS - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic send_row(input logic [4:0] num, input logic [255:0] data,
                          input int hold, input bit with_done);
    cmm_row_num  = num;
    cmm_out      = data;
    cmm_done_row = 1'b1;
    cmm_done     = with_done;
    tick(hold);
    cmm_done_row = 1'b0;
    cmm_done     = 1'b0;
    tick(1);
  endtask

  task automatic send_done();
    cmm_done = 1'b1;
    tick(1);
    cmm_done = 1'b0;
    tick(1);
  endtask

  task automatic make_row(input int r, input bit pattern, output logic [255:0] d);
    for (int w = 0; w < ELEMS; w++)
      d[32*w +: 32] = pattern ? 32'(256 * r + w) : $urandom();
  endtask

  task automatic random_run(input bit pattern);
    logic [255:0] d;
    bit           with_done;
    with_done = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      wait_room();
      make_row(r, pattern, d);
      expect_row(r[4:0], d);
      with_done = (r == ROWS - 1) && ($urandom_range(0, 1) == 1);
      send_row(r[4:0], d, pattern ? 1 : $urandom_range(1, 3), with_done);
      if (r != ROWS - 1 && !pattern && $urandom_range(0, 1) == 1) tick($urandom_range(1, 4));
    end
    if (!with_done) send_done();
  endtask

  task automatic do_job(input logic [7:0] cnt, input bit pattern, input bit poke);
    int s0, l0, j0, runs;
    runs = (cnt == 8'd0) ? 1 : int'(cnt);
    s0 = n_start;
    l0 = n_last;
    j0 = n_jd;
    start_job(cnt);
    for (int k = 0; k < runs; k++) begin
      wait_start(s0 + k + 1);
      if (poke && k == 0) begin
        job_count = 8'd9;
        job_start = 1'b1;
        tick(1);
        job_start = 1'b0;
      end
      random_run(pattern);
    end
    wait_jd(j0 + 1);
    tick(2);
    chk("start_count", n_start - s0, runs);
    chk("last_count", n_last - l0, runs);
    chk("jobdone_count", n_jd - j0, 1);
    chk("flags_clean", {overflow, seq_err}, 0);
    chk("busy_after", busy, 0);
    chk("model_drained", exp_q.size(), 0);
  endtask

  initial begin : stim
    logic [255:0] d;
    int order [4];
    int s0, j0, l0;
    order = '{0, 1, 3, 2};

    tick(3);
    check_zero("reset");
    rst = 1'b0;
    tick(1);
    check_zero("idle");

    // Patterned single run, then multi-run jobs under varied back-pressure.
    rdy_mode = 0;
    do_job(8'd1, 1'b1, 1'b0);
    rdy_mode = 1;
    do_job(8'd3, 1'b0, 1'b1);
    rdy_mode = 2;
    do_job(8'd0, 1'b0, 1'b0);
    do_job(8'd2, 1'b0, 1'b0);

    // Overflow: serializer holds one row, the FIFO four more; the sixth drops.
    rdy_mode = 3;
    tick(2);
    s0 = n_start;
    j0 = n_jd;
    l0 = n_last;
    start_job(8'd1);
    wait_start(s0 + 1);
    for (int r = 0; r < 6; r++) begin
      make_row(r, 1'b1, d);
      if (r < 5) expect_row(r[4:0], d);
      send_row(r[4:0], d, 1, 1'b0);
      if (r == 4) chk("ovf_at_capacity", overflow, 0);
      if (r == 5) chk("ovf_set", overflow, 1);
    end
    send_done();
    rdy_mode = 0;
    wait_jd(j0 + 1);
    tick(2);
    chk("ovf_sticky", overflow, 1);
    chk("ovf_no_seqerr", seq_err, 0);
    chk("ovf_last_count", n_last - l0, 1);
    chk("ovf_model_drained", exp_q.size(), 0);

    // Out-of-order rows: 0,1,3,2.
    s0 = n_start;
    j0 = n_jd;
    start_job(8'd1);
    wait_start(s0 + 1);
    for (int k = 0; k < 4; k++) begin
      make_row(order[k], 1'b0, d);
      expect_row(5'(order[k]), d);
      send_row(5'(order[k]), d, 1, 1'b0);
      chk("seq_err_step", seq_err, (k >= 2) ? 1 : 0);
    end
    send_done();
    wait_jd(j0 + 1);
    tick(2);
    chk("seq_err_sticky", seq_err, 1);
    chk("seq_no_ovf", overflow, 0);
    chk("seq_model_drained", exp_q.size(), 0);

    // Reset mid-stream, stray rows while idle, then a clean job.
    rdy_mode = 1;
    s0 = n_start;
    start_job(8'd2);
    wait_start(s0 + 1);
    for (int r = 0; r < 2; r++) begin
      make_row(r, 1'b0, d);
      expect_row(r[4:0], d);
      send_row(r[4:0], d, 1, 1'b0);
    end
    tick(2);
    rst = 1'b1;
    tick(1);
    check_zero("midjob");
    rst = 1'b0;
    exp_q.delete();
    make_row(2, 1'b0, d);
    send_row(5'd2, d, 1, 1'b0);
    make_row(3, 1'b0, d);
    send_row(5'd3, d, 2, 1'b1);
    tick(3);
    chk("stray_ignored", {m_valid, busy, overflow, seq_err}, 0);
    rdy_mode = 2;
    do_job(8'd1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
